// File: rtl/wb_queue.sv
// In-order register-file write-back queue for ALU results and pending loads.
// Optional WB_QUEUE_BYPASS_EN: an ALU result accepted into an empty queue is written straight to the regfile port.
module wb_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_waddr,
    input  logic [DATA_W-1:0]    alu_wdata,
    input  logic                 ld_issue,
    input  logic [ADDR_W-1:0]    ld_waddr,
    input  logic                 ld_done,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 alloc_ready,
    output logic                 we,
    output logic [ADDR_W-1:0]    waddr,
    output logic [DATA_W-1:0]    wdata,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic                 err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned NREG  = 2**ADDR_W;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  has_q, has_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              alloc_req, alloc_ok, enq, pop, bypass;
    logic              fill_found;
    logic [PTR_W-1:0]  fill_idx, scan_idx;
    logic [NREG-1:0]   busy;

    assign alloc_ready = (count_q < (PTR_W+1)'(DEPTH));
    assign alloc_req   = alu_valid | ld_issue;
    assign alloc_ok    = alloc_req & alloc_ready;
    assign pop         = valid_q[head_q] & has_q[head_q];

`ifdef WB_QUEUE_BYPASS_EN
    assign bypass = alloc_ok & alu_valid & (count_q == '0);
`else
    assign bypass = 1'b0;
`endif
    assign enq = alloc_ok & ~bypass;

    // Oldest pending load is found by scanning from head instead of a
    // separate fill pointer, so interleaved ALU entries are skipped naturally.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (!fill_found && valid_q[scan_idx] && !has_q[scan_idx]) begin
                fill_found = 1'b1;
                fill_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        has_d   = has_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        if (pop) begin
            we_d            = |addr_q[head_q];
            waddr_d         = addr_q[head_q];
            wdata_d         = data_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        if (bypass) begin
            we_d    = |alu_waddr;
            waddr_d = alu_waddr;
            wdata_d = alu_wdata;
        end

        if (ld_done) begin
            if (fill_found) begin
                has_d[fill_idx]  = 1'b1;
                data_d[fill_idx] = ld_data;
            end else begin
                err_d = 1'b1;
            end
        end

        if (alu_valid && ld_issue) err_d = 1'b1;
        if (alloc_req && !alloc_ready) err_d = 1'b1;

        if (enq) begin
            valid_d[tail_q] = 1'b1;
            has_d[tail_q]   = alu_valid;
            addr_d[tail_q]  = alu_valid ? alu_waddr : ld_waddr;
            data_d[tail_q]  = alu_valid ? alu_wdata : '0;
            tail_d          = tail_q + 1'b1;
        end

        count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            has_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            has_q   <= has_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) busy[addr_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    assign busy_mask = busy;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign err       = err_q;

endmodule

// File: doc/wb_queue.md
# wb_queue

In-order write-back queue between the memory stage and the register file write port. It accepts single-cycle ALU results and multi-cycle load reservations, fills each load entry when its data returns, and retires entries strictly in allocation order onto the regfile's `we`/`waddr`/`wdata` port, at most one per cycle. It also publishes a per-register busy mask, which the decode read path uses to report read failure for registers whose newest value is still queued.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2–16.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: data width.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `alu_valid`  in  1  ALU result allocation request.
- `alu_waddr`  in  ADDR_W  ALU destination register.
- `alu_wdata`  in  DATA_W  ALU result.
- `ld_issue`  in  1  load allocation request; data arrives later.
- `ld_waddr`  in  ADDR_W  load destination register.
- `ld_done`  in  1  load data return; returns follow issue order.
- `ld_data`  in  DATA_W  returned load data.
- `alloc_ready`  out  1  queue can accept one allocation this cycle.
- `we`  out  1  regfile write enable (registered).
- `waddr`  out  ADDR_W  regfile write address (registered).
- `wdata`  out  DATA_W  regfile write data (registered).
- `busy_mask`  out  2**ADDR_W  bit r set: register r has an unretired queue entry.
- `err`  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Entry fields: valid, has_data, waddr, data. Head, tail and load-fill pointers wrap modulo DEPTH. A count of 0..DEPTH distinguishes full from empty.
- `alloc_ready` = (count < DEPTH). It is derived from registered state only. A pop in the same cycle does not free a slot for that cycle.
- Allocation at a posedge:
  - `alu_valid` writes a tail entry with has_data=1.
  - `ld_issue` writes a tail entry with has_data=0.
- If `alu_valid` and `ld_issue` are both high, the ALU request wins, the load is dropped, and `err`←1.
- Allocation while `alloc_ready`=0 is dropped and sets `err`←1.
- `ld_done` fills the oldest allocated entry with has_data=0 and advances the load-fill pointer.
  - With no such entry in pre-edge state, `ld_done` is ignored and `err`←1.
  - A load allocated on the same edge is not eligible for that `ld_done`.
- Retire at each posedge: if the pre-edge head is valid with has_data=1, pop it and register `we`←(head.waddr≠0), `waddr`←head.waddr, `wdata`←head.data. Otherwise `we`←0 and `waddr`/`wdata` hold.
- Destination x0:
  - x0 entries are allocated and retired normally, which keeps load ordering intact.
  - They never assert `we`.
  - `busy_mask[0]` is constant 0.
- `busy_mask[r]` = OR over valid entries of (entry.waddr==r), for r≠0. It is computed from registered state. Once an entry is in the `we` output register, the regfile's own forwarding covers it and its bit clears.
- Allocate, fill and retire may all occur on one edge. Each acts on pre-edge state, and count updates by (+alloc −pop).

## Timing
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `busy_mask`=0, `err`=0, `alloc_ready`=1; all entries invalid; all pointers 0.
- Reset mid-operation discards every queued entry and outstanding load. Any later `ld_done` sets `err`.
- ALU latency: accepted at edge E0, head at E0 if the queue was empty, popped at E1, `we` high in the cycle after E1, regfile write at E2.
- Load latency: `ld_done` at edge Ef on the head entry → popped at Ef+1 → `we` high after Ef+1.
- Sustained throughput: one retire per cycle while the head entry has data.
- A pending head load blocks all younger entries, including ready ALU entries.

## Configuration
- `WB_QUEUE_BYPASS_EN` defined: if the pre-edge count is 0 and `alu_valid` is accepted, the result goes straight into the `we`/`waddr`/`wdata` registers at E0 and is not enqueued. ALU latency is one edge shorter, and the bypassed write never appears in `busy_mask`.
- Undefined: every allocation passes through the queue as described above.

## Test plan
- ALU stream: `alu_valid` for 3 cycles, x1=0x11, x2=0x22, x3=0x33 → `we` pulses 3 consecutive cycles in order. First pulse is after E1 (after E0 with bypass).
- Load blocking:
  - ld_issue x5, then alu x6=0x66; `ld_done` 0xAB five cycles later.
  - `busy_mask` bits 5 and 6 stay set until then.
  - Writes then occur as x5=0xAB followed by x6=0x66.
- Full: DEPTH=4, four ld_issue → `alloc_ready`=0. A fifth alu_valid is dropped and sets `err`=1. Four `ld_done` later the queue drains in order.
- x0 handling: ld_issue x0, `ld_done` 0xFF → no `we` pulse; `busy_mask`=0 throughout; next ld_issue x7 fills correctly.
- Error/reset:
  - `ld_done` with nothing outstanding → `err`=1 and no state change.
  - `rst` asserted with 3 queued entries → all outputs return to reset values on the next edge.
  - A subsequent `ld_done` sets `err` again.
